// File: rtl/mem_port_arbiter.sv
// Shares one request/acknowledge memory port between instruction fetch and data access.
// Data wins arbitration unless fetch has lost STARVE consecutive rounds.
module mem_port_arbiter #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned STARVE = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_done_o,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_stall_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_done_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          dm_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [15:0]   conflict_cnt_o
);

  typedef enum logic [1:0] {StIdle, StGntD, StGntI, StResp} state_e;

  localparam logic [3:0] StarveCnt = 4'(STARVE);

  state_e        state_q;
  logic [3:0]    deny_q;
  logic [15:0]   conflict_q;
  logic          mem_req_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          if_done_q, dm_done_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;
  logic          fetch_wins;

  // Fetch wins when starved, or when data is not asking at all.
  assign fetch_wins = if_req_i && ((deny_q == StarveCnt) || !dm_req_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      deny_q      <= '0;
      conflict_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_req_i && dm_req_i && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
          end
          if (fetch_wins) begin
            state_q     <= StGntI;
            deny_q      <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
          end else if (dm_req_i) begin
            state_q     <= StGntD;
            mem_req_q   <= 1'b1;
            mem_we_q    <= dm_we_i;
            mem_addr_q  <= dm_addr_i;
            mem_wdata_q <= dm_wdata_i;
            if (!if_req_i) begin
              deny_q <= '0;
            end else if (deny_q != StarveCnt) begin
              deny_q <= deny_q + 4'd1;
            end
          end else begin
            deny_q <= '0;
          end
        end
        StGntD: begin
          if (mem_ack_i) begin
            state_q   <= StResp;
            mem_req_q <= 1'b0;
            dm_done_q <= 1'b1;
            if (!mem_we_q) begin
              dm_rdata_q <= mem_rdata_i;
            end
          end
        end
        StGntI: begin
          if (mem_ack_i) begin
            state_q    <= StResp;
            mem_req_q  <= 1'b0;
            if_done_q  <= 1'b1;
            if_rdata_q <= mem_rdata_i;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign if_done_o      = if_done_q;
  assign if_rdata_o     = if_rdata_q;
  assign if_stall_o     = if_req_i & ~if_done_q;
  assign dm_done_o      = dm_done_q;
  assign dm_rdata_o     = dm_rdata_q;
  assign dm_stall_o     = dm_req_i & ~dm_done_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences and a
// randomized run against a cycle-timeline reference model.
`define CHK(n, a, e) chk(n, 64'(a), 64'(e))

module tb_mem_port_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned STARVE = 4;

  logic clk = 1'b0;
  logic rst;
  logic if_req, dm_req, dm_we, mem_ack;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic if_done, if_stall, dm_done, dm_stall, mem_req, mem_we;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [15:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done),
    .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_done_o(dm_done), .dm_rdata_o(dm_rdata), .dm_stall_o(dm_stall),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .conflict_cnt_o(conflict_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic          dm;
    logic          we;
    logic [15:0]   addr;
    logic [15:0]   wdata;
    int            waits;
    logic [15:0]   rdata;
    logic [15:0]   exp_wdata;
    logic [15:0]   exp_if_rd;
    logic [15:0]   exp_dm_rd;
  } vec_t;

  vec_t vecs[5];

  // One isolated access from an idle arbiter, acked after v.waits extra cycles.
  task automatic run_vec(input vec_t v);
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr; dm_wdata = v.wdata;
    end
    #1;
    `CHK("stall_on_req", v.dm ? dm_stall : if_stall, 1'b1);
    for (int w = 0; w <= v.waits; w++) begin
      tick();
      `CHK("vec_mem_req", mem_req, 1'b1);
      `CHK("vec_mem_we", mem_we, v.dm & v.we);
      `CHK("vec_mem_addr", mem_addr, v.addr);
      `CHK("vec_mem_wdata", mem_wdata, v.exp_wdata);
      `CHK("vec_no_early_done", {if_done, dm_done}, 2'b00);
      `CHK("vec_stall_wait", v.dm ? dm_stall : if_stall, 1'b1);
      mem_ack = (w == v.waits);
      mem_rdata = (w == v.waits) ? v.rdata : 16'hDEAD;
    end
    tick();
    mem_ack = 1'b0;
    mem_rdata = 16'h0BAD;
    `CHK("vec_done", {if_done, dm_done}, v.dm ? 2'b01 : 2'b10);
    `CHK("vec_if_rdata", if_rdata, v.exp_if_rd);
    `CHK("vec_dm_rdata", dm_rdata, v.exp_dm_rd);
    `CHK("vec_mem_req_resp", mem_req, 1'b0);
    `CHK("vec_stall_done", v.dm ? dm_stall : if_stall, 1'b0);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    `CHK("vec_done_pulse", {if_done, dm_done}, 2'b00);
    `CHK("vec_idle_mem_req", mem_req, 1'b0);
  endtask

  // Reference-model state for the random run.
  int owner, grant_cyc, next_arb, done_cyc, done_owner, losses, winner;
  logic e_we;
  logic [15:0] e_addr, e_wdata, e_if_rd, e_dm_rd, e_conf;
  bit f_pend, d_pend;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'hAAAA, 0, 16'hB0FF, 16'h0000, 16'hB0FF, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 3, 16'hDEAD, 16'h1234, 16'hB0FF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0300, 16'h7777, 1, 16'h5A5A, 16'h7777, 16'hB0FF, 16'h5A5A};
    vecs[3] = '{1'b0, 1'b0, 16'h0012, 16'h9999, 2, 16'h1111, 16'h0000, 16'h1111, 16'h5A5A};
    vecs[4] = '{1'b1, 1'b1, 16'h0400, 16'hFFFF, 0, 16'h2222, 16'hFFFF, 16'h1111, 16'h5A5A};

    do_reset();
    `CHK("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, 34'h0);
    `CHK("rst_done", {if_done, dm_done}, 2'b00);
    `CHK("rst_rdata", {if_rdata, dm_rdata}, 32'h0);
    `CHK("rst_conflict", conflict_cnt, 16'h0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    `CHK("vec_no_conflict", conflict_cnt, 16'h0);

    // Contention: four data wins, then fetch is forced through, and again.
    do_reset();
    begin
      int dn;
      bit exp_i;
      dn = 0;
      if_req = 1'b1; if_addr = 16'h0100;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0A00;
      for (int g = 0; g < 10; g++) begin
        exp_i = ((g % 5) == 4);
        tick();
        `CHK("arb_grant_addr", mem_addr, exp_i ? 16'h0100 : 16'(16'h0A00 + dn));
        `CHK("arb_conflict", conflict_cnt, g + 1);
        mem_ack = 1'b1;
        mem_rdata = 16'(16'hC000 + g);
        tick();
        mem_ack = 1'b0;
        `CHK("arb_done", {if_done, dm_done}, exp_i ? 2'b10 : 2'b01);
        if (!exp_i) begin
          dn++;
          dm_addr = 16'(16'h0A00 + dn);
        end
        tick();
      end
      if_req = 1'b0;
      dm_req = 1'b0;
    end

    // Reset while data access is waiting for ack.
    do_reset();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0055; dm_wdata = 16'h4242;
    if_req = 1'b1; if_addr = 16'h0066;
    tick();
    `CHK("rstmid_granted", {mem_req, mem_addr}, {1'b1, 16'h0055});
    `CHK("rstmid_conflict_pre", conflict_cnt, 16'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    `CHK("rstmid_mem_req", mem_req, 1'b0);
    `CHK("rstmid_done", {if_done, dm_done}, 2'b00);
    `CHK("rstmid_conflict", conflict_cnt, 16'h0);
    dm_req = 1'b0; if_req = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hEEEE;
    tick();
    tick();
    mem_ack = 1'b0;
    `CHK("late_ack_done", {if_done, dm_done}, 2'b00);
    `CHK("late_ack_rdata", {if_rdata, dm_rdata}, 32'h0);
    `CHK("late_ack_state", {mem_req, mem_addr, conflict_cnt}, 33'h0);

    // Fetch drops its request mid-grant; the access still completes.
    if_req = 1'b1; if_addr = 16'h0077;
    tick();
    `CHK("drop_granted", {mem_req, mem_addr}, {1'b1, 16'h0077});
    if_req = 1'b0;
    tick();
    `CHK("drop_held", mem_req, 1'b1);
    mem_ack = 1'b1; mem_rdata = 16'h3C3C;
    tick();
    mem_ack = 1'b0;
    `CHK("drop_done", {if_done, dm_done}, 2'b10);
    `CHK("drop_rdata", if_rdata, 16'h3C3C);
    tick();
    `CHK("drop_done_once", if_done, 1'b0);
    tick();
    `CHK("drop_no_regrant", mem_req, 1'b0);

    // Saturation of the contention counter.
    do_reset();
    force dut.conflict_q = 16'hFFFE;
    tick();
    release dut.conflict_q;
    #1;
    `CHK("sat_preload", conflict_cnt, 16'hFFFE);
    if_req = 1'b1; if_addr = 16'h0001;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0002;
    tick();
    `CHK("sat_reach", conflict_cnt, 16'hFFFF);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    dm_addr = 16'h0003;
    tick();
    tick();
    `CHK("sat_hold", conflict_cnt, 16'hFFFF);
    if_req = 1'b0; dm_req = 1'b0;

    // Randomized traffic against the timeline model.
    do_reset();
    owner = 0; grant_cyc = 0; next_arb = 0; done_cyc = -1; done_owner = 0; losses = 0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_if_rd = '0; e_dm_rd = '0; e_conf = '0;
    f_pend = 1'b0; d_pend = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      bit e_mreq, ack, d_i, d_d;
      e_mreq = (owner != 0) && (t > grant_cyc);
      d_i = (done_cyc == t) && (done_owner == 1);
      d_d = (done_cyc == t) && (done_owner == 2);
      n_chk++;
      if (mem_req !== e_mreq) begin
        n_fail++;
        $display("FAIL rnd_mem_req_inl: got %0b, expected %0b (t=%0t)", mem_req, e_mreq, $time);
      end
      n_chk++;
      if ({if_done, dm_done} !== {d_i, d_d}) begin
        n_fail++;
        $display("FAIL rnd_done_inl: got %0b%0b, expected %0b%0b (t=%0t)",
                 if_done, dm_done, d_i, d_d, $time);
      end
      `CHK("rnd_mem_req", mem_req, e_mreq);
      `CHK("rnd_mem_fields", {mem_we, mem_addr, mem_wdata}, {e_we, e_addr, e_wdata});
      `CHK("rnd_done", {if_done, dm_done}, {d_i, d_d});
      `CHK("rnd_rdata", {if_rdata, dm_rdata}, {e_if_rd, e_dm_rd});
      `CHK("rnd_conflict", conflict_cnt, e_conf);
      `CHK("rnd_stall", {if_stall, dm_stall}, {if_req & ~d_i, dm_req & ~d_d});
      if (d_i) f_pend = 1'b0;
      if (d_d) d_pend = 1'b0;
      if (!f_pend && ($urandom_range(1, 0) == 1)) begin
        f_pend = 1'b1;
        if_addr = 16'($urandom);
      end
      if (!d_pend && ($urandom_range(2, 0) != 0)) begin
        d_pend = 1'b1;
        dm_we = 1'($urandom);
        dm_addr = 16'($urandom);
        dm_wdata = 16'($urandom);
      end
      if_req = f_pend;
      dm_req = d_pend;
      ack = e_mreq ? ($urandom_range(2, 0) == 0) : ($urandom_range(7, 0) == 0);
      mem_ack = ack;
      mem_rdata = 16'($urandom);
      if (e_mreq && ack) begin
        done_cyc = t + 1;
        done_owner = owner;
        if (owner == 1) e_if_rd = mem_rdata;
        else if (!e_we) e_dm_rd = mem_rdata;
        owner = 0;
        next_arb = t + 2;
      end else if (t == next_arb) begin
        if (if_req && dm_req && (e_conf != 16'hFFFF)) e_conf = e_conf + 16'd1;
        if (if_req && (losses == int'(STARVE))) winner = 1;
        else if (dm_req) winner = 2;
        else if (if_req) winner = 1;
        else winner = 0;
        if (!if_req || (winner == 1)) losses = 0;
        else losses++;
        if (winner == 0) begin
          next_arb = t + 1;
        end else begin
          owner = winner;
          grant_cyc = t;
          e_we = (winner == 2) && dm_we;
          e_addr = (winner == 1) ? if_addr : dm_addr;
          e_wdata = (winner == 2) ? dm_wdata : 16'h0;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
